// File: rtl/intfsm_param.sv
// Init/idle/active/error controller for the QoS FIFO path.
// Latches per-FIFO thresholds in INIT and tracks link state and sticky errors.
module intfsm_param #(
   parameter int NUM_FIFOS = 5,
   parameter int TH_W      = 4,
   parameter int IDLE_HOLD = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      init,
   input  logic                      err_clr,
   input  logic [NUM_FIFOS-1:0]      fifo_empty,
   input  logic [NUM_FIFOS-1:0]      fifo_error,
   input  logic [NUM_FIFOS*TH_W-1:0] umbral_hi_in,
   input  logic [NUM_FIFOS*TH_W-1:0] umbral_lo_in,
   output logic [NUM_FIFOS*TH_W-1:0] umbral_hi_out,
   output logic [NUM_FIFOS*TH_W-1:0] umbral_lo_out,
   output logic                      idle_out,
   output logic                      active_out,
   output logic                      error_out,
   output logic [NUM_FIFOS-1:0]      error_full,
   output logic                      cfg_err,
   output logic [2:0]                state_out
);

   localparam int CNT_W = $clog2(IDLE_HOLD + 1);

   typedef enum logic [2:0] {
      S_RESET  = 3'd0,
      S_INIT   = 3'd1,
      S_IDLE   = 3'd2,
      S_ACTIVE = 3'd3,
      S_ERROR  = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] hold_q, hold_d, hold_inc;
   logic             cfg_bad;
   logic             cfg_set;
   logic             clr;
   logic             any_err;
   logic             all_empty;

   assign any_err   = |fifo_error;
   assign all_empty = &fifo_empty;
   assign state_out = state_q;

   // saturating increment keeps the counter from wrapping
   assign hold_inc = (hold_q == {CNT_W{1'b1}}) ? hold_q : hold_q + CNT_W'(1);

   always_comb begin
      cfg_bad = 1'b0;
      for (int i = 0; i < NUM_FIFOS; i++) begin
         if (umbral_lo_in[i*TH_W +: TH_W] > umbral_hi_in[i*TH_W +: TH_W])
            cfg_bad = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      hold_d  = '0;
      cfg_set = 1'b0;
      clr     = 1'b0;
      unique case (state_q)
         S_RESET: state_d = S_INIT;
         S_INIT: begin
            if (any_err)
               state_d = S_ERROR;
            else if (init)
               state_d = S_INIT;
            else if (cfg_bad) begin
               state_d = S_ERROR;
               cfg_set = 1'b1;
            end else
               state_d = S_IDLE;
         end
         S_IDLE: begin
            if (any_err)
               state_d = S_ERROR;
            else if (init)
               state_d = S_INIT;
            else if (!all_empty)
               state_d = S_ACTIVE;
         end
         S_ACTIVE: begin
            if (any_err)
               state_d = S_ERROR;
            else if (init)
               state_d = S_INIT;
            else if (all_empty) begin
               if (hold_inc >= CNT_W'(IDLE_HOLD))
                  state_d = S_IDLE;
               else
                  hold_d = hold_inc;
            end
         end
         S_ERROR: begin
            if (err_clr) begin
               state_d = S_INIT;
               clr     = 1'b1;
            end
         end
         default: state_d = S_RESET;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_RESET;
         hold_q        <= '0;
         idle_out      <= 1'b0;
         active_out    <= 1'b0;
         error_out     <= 1'b0;
         error_full    <= '0;
         cfg_err       <= 1'b0;
         umbral_hi_out <= '0;
         umbral_lo_out <= '0;
      end else begin
         state_q    <= state_d;
         hold_q     <= hold_d;
         idle_out   <= (state_d == S_IDLE);
         active_out <= (state_d == S_ACTIVE);
         error_out  <= (state_d == S_ERROR);
         // a clear drops any error bits arriving on the same edge
         error_full <= clr ? '0 : (error_full | fifo_error);
         cfg_err    <= clr ? 1'b0 : (cfg_err | cfg_set);
         if (state_q == S_INIT) begin
            umbral_hi_out <= umbral_hi_in;
            umbral_lo_out <= umbral_lo_in;
         end
      end
   end

endmodule

// File: tb/tb_intfsm_param.sv
// Bench for intfsm_param: directed scenarios plus random traffic
// checked every cycle against a state-level reference model.
module tb_intfsm_param;

   localparam int N  = 5;
   localparam int TW = 4;
   localparam int HOLD = 4;

   logic          clk = 1'b0;
   logic          reset, init, err_clr;
   logic [N-1:0]  fifo_empty, fifo_error;
   logic [N*TW-1:0] hi_in, lo_in;
   logic [N*TW-1:0] hi_out, lo_out;
   logic          idle_out, active_out, error_out, cfg_err;
   logic [N-1:0]  error_full;
   logic [2:0]    state_out;

   int n_tests = 0;
   int n_fail  = 0;

   int            m_st, m_run;
   logic [N-1:0]  m_ef;
   logic          m_cfg;
   logic [N*TW-1:0] m_hi, m_lo;

   intfsm_param #(.NUM_FIFOS(N), .TH_W(TW), .IDLE_HOLD(HOLD)) dut (
      .clk(clk), .reset(reset), .init(init), .err_clr(err_clr),
      .fifo_empty(fifo_empty), .fifo_error(fifo_error),
      .umbral_hi_in(hi_in), .umbral_lo_in(lo_in),
      .umbral_hi_out(hi_out), .umbral_lo_out(lo_out),
      .idle_out(idle_out), .active_out(active_out),
      .error_out(error_out), .error_full(error_full),
      .cfg_err(cfg_err), .state_out(state_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit any_bad();
      for (int i = 0; i < N; i++)
         if (lo_in[i*TW +: TW] > hi_in[i*TW +: TW]) return 1'b1;
      return 1'b0;
   endfunction

   // reference: 0 reset, 1 init, 2 idle, 3 active, 4 error
   task automatic model_update();
      int nx;
      if (reset) begin
         m_st = 0; m_run = 0; m_ef = '0; m_cfg = 1'b0;
         m_hi = '0; m_lo = '0;
         return;
      end
      nx = m_st;
      if (m_st == 4 && err_clr) begin
         m_ef = '0; m_cfg = 1'b0; nx = 1;
      end else
         m_ef = m_ef | fifo_error;
      case (m_st)
         0: nx = 1;
         1: begin
            m_hi = hi_in; m_lo = lo_in;
            if (fifo_error != 0) nx = 4;
            else if (init) nx = 1;
            else if (any_bad()) begin nx = 4; m_cfg = 1'b1; end
            else nx = 2;
         end
         2: begin
            if (fifo_error != 0) nx = 4;
            else if (init) nx = 1;
            else if (fifo_empty != {N{1'b1}}) nx = 3;
         end
         3: begin
            if (fifo_error != 0) nx = 4;
            else if (init) nx = 1;
            else if (fifo_empty == {N{1'b1}}) begin
               m_run++;
               if (m_run >= HOLD) nx = 2;
            end else m_run = 0;
         end
         4: ;
         default: nx = 0;
      endcase
      if (nx != 3) m_run = 0;
      m_st = nx;
   endtask

   task automatic check_all();
      chk("state", 32'(state_out), 32'(m_st));
      chk("idle", 32'(idle_out), 32'(m_st == 2));
      chk("active", 32'(active_out), 32'(m_st == 3));
      chk("error", 32'(error_out), 32'(m_st == 4));
      chk("error_full", 32'(error_full), 32'(m_ef));
      chk("cfg_err", 32'(cfg_err), 32'(m_cfg));
      chk("hi_out", 32'(hi_out), 32'(m_hi));
      chk("lo_out", 32'(lo_out), 32'(m_lo));
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      check_all();
      init = 1'b0; err_clr = 1'b0; fifo_error = '0;
   endtask

   task automatic go_idle();
      reset = 1'b1; step();
      reset = 1'b0;
      hi_in = {N{4'hC}}; lo_in = {N{4'h2}};
      fifo_empty = '1;
      step(); step();
   endtask

   initial begin
      reset = 1'b1; init = 1'b0; err_clr = 1'b0;
      fifo_empty = '1; fifo_error = '0;
      hi_in = {N{4'hC}}; lo_in = {N{4'h2}};
      m_st = 0; m_run = 0; m_ef = '0; m_cfg = 1'b0; m_hi = '0; m_lo = '0;

      step(); step();
      chk("t1_reset_state", 32'(state_out), 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         init = 1'b1; step();
         chk("t1_init_state", 32'(state_out), 32'd1);
      end
      step();
      chk("t1_idle", 32'(idle_out), 32'd1);
      chk("t1_hi", 32'(hi_out), 32'hCCCCC);
      chk("t1_lo", 32'(lo_out), 32'h22222);

      fifo_empty = 5'b11110; step();
      chk("t2_active", 32'(state_out), 32'd3);
      fifo_empty = 5'b11111;
      for (int i = 0; i < 3; i++) step();
      chk("t2_still_active", 32'(active_out), 32'd1);
      step();
      chk("t2_back_idle", 32'(state_out), 32'd2);
      fifo_empty = 5'b11110; step();
      fifo_empty = 5'b11111; step(); step();
      fifo_empty = 5'b01111; step();
      fifo_empty = 5'b11111; step(); step(); step();
      chk("t2_restart_active", 32'(state_out), 32'd3);
      step();
      chk("t2_restart_idle", 32'(state_out), 32'd2);

      fifo_empty = 5'b11010; step();
      fifo_error = 5'b00100; step();
      chk("t3_error", 32'(state_out), 32'd4);
      chk("t3_ef1", 32'(error_full), 32'h04);
      fifo_error = 5'b00001; step();
      chk("t3_ef2", 32'(error_full), 32'h05);
      init = 1'b1; step();
      chk("t3_init_ignored", 32'(state_out), 32'd4);
      err_clr = 1'b1; fifo_error = 5'b01000; init = 1'b1; step();
      chk("t3_clr_state", 32'(state_out), 32'd1);
      chk("t3_clr_ef", 32'(error_full), 32'd0);
      chk("t3_clr_cfg", 32'(cfg_err), 32'd0);

      fifo_empty = '1;
      hi_in[15:12] = 4'h3; lo_in[15:12] = 4'h9;
      init = 1'b1; step();
      step();
      chk("t4_state", 32'(state_out), 32'd4);
      chk("t4_cfg_err", 32'(cfg_err), 32'd1);
      chk("t4_ef", 32'(error_full), 32'd0);
      err_clr = 1'b1; step();
      hi_in = {N{4'hC}}; lo_in = {N{4'h2}};
      step(); step();
      chk("t4_recover_idle", 32'(state_out), 32'd2);

      fifo_empty = 5'b00000; step();
      reset = 1'b1; step();
      chk("t5_active_reset", 32'(state_out), 32'd0);
      chk("t5_active_reset_hi", 32'(hi_out), 32'd0);
      go_idle();
      fifo_error = 5'b00010; step();
      reset = 1'b1; step();
      chk("t5_error_reset", 32'(error_out), 32'd0);
      chk("t5_error_reset_ef", 32'(error_full), 32'd0);

      go_idle();
      chk("t6_pre_idle", 32'(state_out), 32'd2);
      init = 1'b1; fifo_error = 5'b10000; step();
      chk("t6_error_prio", 32'(state_out), 32'd4);
      chk("t6_ef", 32'(error_full), 32'h10);

      for (int c = 0; c < 3000; c++) begin
         reset   = ($urandom_range(0, 63) == 0);
         init    = ($urandom_range(0, 7) == 0);
         err_clr = ($urandom_range(0, 7) == 0);
         fifo_error = ($urandom_range(0, 11) == 0) ? N'($urandom) : '0;
         fifo_empty = ($urandom_range(0, 1) == 0) ? '1 : N'($urandom);
         if ($urandom_range(0, 15) == 0) begin
            hi_in = (N*TW)'($urandom);
            lo_in = (N*TW)'($urandom) & {N{4'h7}};
         end
         step();
         reset = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
